// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus: program control, branch request,
// instruction memory read and fetch-register outputs.
interface instr_fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        branch_en;
  logic        branch_rel;
  logic [9:0]  branch_target;
  logic [7:0]  branch_offset;
  logic [8:0]  mem_data;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic [9:0]  fetch_pc;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic [15:0] retired_count;

  modport master (
    output start, stall, branch_en, branch_rel,
    output branch_target, branch_offset, mem_data,
    input  pc, instr_out, fetch_pc, instr_valid,
    input  busy, done, retired_count
  );

  modport slave (
    input  start, stall, branch_en, branch_rel,
    input  branch_target, branch_offset, mem_data,
    output pc, instr_out, fetch_pc, instr_valid,
    output busy, done, retired_count
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the pc, a one-stage
// fetch register, start/halt control and branch redirect.
module instr_fetch_ctrl #(
  parameter logic [9:0] START_PC   = 10'd0,
  parameter logic [8:0] HALT_INSTR = 9'h1FF,
  parameter logic [8:0] NOP_INSTR  = 9'b101100100
) (
  input logic clk,
  input logic reset,
  instr_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [9:0]  pc_q, pc_n;
  logic [9:0]  fpc_q, fpc_n;
  logic [8:0]  ins_q, ins_n;
  logic        vld_q, vld_n;
  logic [15:0] cnt_q, cnt_n;
  logic [9:0]  rel_pc;

  assign rel_pc = fpc_q +
    {{2{bus.branch_offset[7]}}, bus.branch_offset};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q  <= START_PC;
      fpc_q <= START_PC;
      ins_q <= NOP_INSTR;
      vld_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      fpc_q <= fpc_n;
      ins_q <= ins_n;
      vld_q <= vld_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    fpc_n   = fpc_q;
    ins_n   = ins_q;
    vld_n   = vld_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = RUN;
          pc_n    = START_PC;
          fpc_n   = START_PC;
          ins_n   = NOP_INSTR;
          vld_n   = 1'b0;
          cnt_n   = 16'd0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (vld_q && ins_q == HALT_INSTR) begin
            state_n = DONE;
            vld_n   = 1'b0;
            ins_n   = NOP_INSTR;
          end else if (vld_q && bus.branch_en) begin
            // redirect and flush the word already in flight
            pc_n  = bus.branch_rel ? rel_pc
                                   : bus.branch_target;
            vld_n = 1'b0;
            ins_n = NOP_INSTR;
          end else begin
            ins_n = bus.mem_data;
            fpc_n = pc_q;
            vld_n = 1'b1;
            pc_n  = pc_q + 10'd1;
          end
          if (vld_q && cnt_q != 16'hFFFF)
            cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pc            = pc_q;
  assign bus.fetch_pc      = fpc_q;
  assign bus.instr_out     = ins_q;
  assign bus.instr_valid   = vld_q;
  assign bus.retired_count = cnt_q;
  assign bus.busy          = (state == RUN);
  assign bus.done          = (state == DONE);

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the 1024 x 9-bit instruction memory. Owns the 10-bit program counter and registers the fetched word into a 1-stage fetch register for the datapath.
- Handles start/halt, datapath stalls, and absolute or relative branches, with a bubble-flush on a taken branch.
- Sits between the instruction memory (combinational read, addressed by pc) and the decode/execute datapath.

Parameters:
START_PC, 10'd0, pc loaded on start and after reset
HALT_INSTR, 9'h1FF, instruction word that ends the program
NOP_INSTR, 9'b101100100, value driven on instr_out when no valid instruction is held

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from START_PC when idle or done
stall  in  1  datapath hold; freezes pc and the fetch register
branch_en  in  1  branch taken by the instruction currently on instr_out
branch_rel  in  1  1 = relative branch, 0 = absolute branch
branch_target  in  10  absolute branch target
branch_offset  in  8  signed offset, relative to fetch_pc
mem_data  in  9  instruction memory read data for the current pc
pc  out  10  instruction memory address
instr_out  out  9  registered instruction
fetch_pc  out  10  address that instr_out was fetched from
instr_valid  out  1  instr_out holds a real instruction
busy  out  1  state is RUN
done  out  1  HALT_INSTR has retired; held high until the next start
retired_count  out  16  number of retired instructions since the last start

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (from any state, mid-run included) forces: IDLE, pc=START_PC, fetch_pc=START_PC, instr_out=NOP_INSTR, instr_valid=0, busy=0, done=0, retired_count=0.
- IDLE:
  - Holds all outputs at their reset values.
  - start -> RUN next cycle, with pc=START_PC, instr_valid=0, retired_count=0.
- RUN, normal fetch (stall=0):
  - instr_out<=mem_data, fetch_pc<=pc, instr_valid<=1, pc<=pc+1.
  - First valid instruction appears 2 cycles after the start pulse.
- Retire condition: instr_valid=1 and stall=0.
  - retired_count increments on retire.
  - Saturates at 16'hFFFF; no wrap.
- Branch, evaluated only on retire of a non-halt instruction with branch_en=1:
  - Absolute: pc<=branch_target.
  - Relative: pc<=fetch_pc + sign-extended branch_offset.
  - Both are modulo 1024: wrap silently in either direction.
  - Next cycle: instr_valid=0 and instr_out=NOP_INSTR. The sequential word is flushed, giving exactly 1 bubble.
  - The cycle after that delivers Core[target].
- branch_en while instr_valid=0 is ignored.
- Stall:
  - pc, instr_out, fetch_pc, instr_valid and retired_count all hold.
  - branch_en is ignored during stall. The datapath keeps branch_en asserted until stall drops.
- Halt: on retire of instr_out==HALT_INSTR:
  - -> DONE. done=1, busy=0, instr_valid=0, instr_out=NOP_INSTR.
  - pc and fetch_pc frozen.
  - The halt word is counted in retired_count.
  - branch_en in the same cycle is ignored.
- DONE:
  - done and retired_count hold.
  - start -> RUN exactly as from IDLE, and done clears.
- start while in RUN is ignored.
- pc sequential overflow: 1023+1 -> 0, with no flag.
- busy=1 exactly in RUN. done=1 exactly in DONE.

Test Plan:
- Sequential fetch: memory holds 9'h001..9'h005 at addresses 0..4, HALT_INSTR at 5. Pulse start -> instr_valid first high 2 cycles later with fetch_pc=0 and instr_out=9'h001; fetch_pc then steps 1..5; done=1 after HALT retires; retired_count=6; pc frozen.
- Absolute branch: branch_en=1, branch_rel=0, target=10'd200 while fetch_pc=3 -> next cycle instr_valid=0 and instr_out=NOP_INSTR; following cycle fetch_pc=200 and instr_out=Core[200]; retired_count excludes the bubble.
- Relative branch with wrap: fetch_pc=2, offset=8'hFC (-4) -> fetch_pc=1022 after the bubble. Separately, sequential fetch from 1023 -> fetch_pc=0 next.
- Stall: 3-cycle stall while instr_out=9'h003 with branch_en=1 -> outputs and count held for 3 cycles; branch taken only on the first cycle with stall=0.
- Reset mid-run at fetch_pc=7 -> next cycle IDLE, pc=0, instr_valid=0, retired_count=0; a later start re-runs from START_PC.
- Restart from DONE: pulse start after halt -> done=0, retired_count=0, first valid instruction at START_PC 2 cycles later. A start pulse issued during RUN has no effect.
